// File: rtl/img_ram_pkg.sv
// img_ram_pkg: shared state type, framing byte and default geometry for the image RAM controller
package img_ram_pkg;
  typedef enum logic [2:0] {IDLE, HI, LO, TAIL, DONE} state_e;
  localparam logic [7:0] HDR_BYTE   = 8'h5A;
  localparam int         ADDR_W_DEF = 15;
  localparam int         DATA_W_DEF = 12;
  localparam int         IMG_W_DEF  = 160;
  localparam int         IMG_H_DEF  = 120;
endpackage

// File: rtl/img_pix_assembler.sv
// img_pix_assembler: pairs a high byte with the upper bits of the following low byte into one pixel strobe
module img_pix_assembler #(
  parameter int DATA_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        byte_i,
  input  logic              hi_en_i,
  input  logic              lo_en_i,
  output logic [DATA_W-1:0] pix_o,
  output logic              pix_stb_o
);
  logic [7:0] hi_q;
  logic       unused_lo;
  // hold the high byte until its partner low byte arrives
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) hi_q <= '0;
    else if (hi_en_i) hi_q <= byte_i;
  assign pix_o     = {hi_q, byte_i[7 -: DATA_W-8]};
  assign pix_stb_o = lo_en_i;
  assign unused_lo = ^byte_i[15-DATA_W:0];
endmodule

// File: rtl/img_ram_ctrl.sv
// img_ram_ctrl: framed pixel stream to SRAM writer with write-priority display read arbitration.
// Optional inter-byte timeout enabled by defining IMG_RAM_TIMEOUT_EN.
module img_ram_ctrl
  import img_ram_pkg::*;
#(
  parameter int IMG_W          = IMG_W_DEF,
  parameter int IMG_H          = IMG_H_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_gnt,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic              o_ram_wre,
  output logic              o_ram_ce,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic              o_image_receiving,
  output logic              o_image_complete,
  output logic              o_image_reading,
  output logic              o_frame_err,
  output logic [ADDR_W-1:0] o_pixcnt
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pixcnt_q, pixcnt_d, ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d, pix;
  logic              recv_q, recv_d, comp_q, comp_d, read_q, read_d, err_q, err_d;
  logic              wre_q, ce_q, gnt_q, rvalid_q;
  logic              hdr, wr, rd, tmo;

  assign hdr = i_byte_valid && i_byte == HDR_BYTE;
  assign rd  = i_rd_req && !wr;

  img_pix_assembler #(.DATA_W(DATA_W)) u_pix (
    .clk_i    (i_clk_sys),
    .rst_ni   (i_rst_n),
    .byte_i   (i_byte),
    .hi_en_i  (i_byte_valid && state_q == HI),
    .lo_en_i  (i_byte_valid && state_q == LO),
    .pix_o    (pix),
    .pix_stb_o(wr)
  );

`ifdef IMG_RAM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          active;
  assign active = state_q inside {HI, LO, TAIL};
  assign tmo    = active && !i_byte_valid && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  // count silent cycles since the last byte while a frame is open
  always_ff @(posedge i_clk_sys or negedge i_rst_n)
    if (!i_rst_n) tmo_q <= '0;
    else tmo_q <= (active && !i_byte_valid && !tmo) ? tmo_q + 1'b1 : '0;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  // frame parser next state; a header in IDLE or DONE restarts everything
  always_comb begin
    state_d  = state_q;
    pixcnt_d = pixcnt_q;
    recv_d   = recv_q;
    comp_d   = comp_q;
    read_d   = read_q | (rd & comp_q);
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: if (hdr) begin
        state_d  = HI;
        pixcnt_d = '0;
        recv_d   = 1'b1;
        comp_d   = 1'b0;
        read_d   = 1'b0;
        err_d    = 1'b0;
      end
      HI: if (i_byte_valid) state_d = LO;
      LO: if (i_byte_valid) begin
        pixcnt_d = pixcnt_q + 1'b1;
        state_d  = (pixcnt_q == LAST) ? TAIL : HI;
      end
      TAIL: if (i_byte_valid) begin
        state_d = hdr ? DONE : IDLE;
        comp_d  = hdr;
        err_d   = !hdr;
        recv_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d = IDLE;
      err_d   = 1'b1;
      recv_d  = 1'b0;
    end
  end

  assign ram_addr_d = wr ? pixcnt_q : rd ? i_rd_addr : ram_addr_q;
  assign ram_din_d  = wr ? pix : ram_din_q;

  // parser state, status flags and the registered RAM port
  always_ff @(posedge i_clk_sys or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q    <= IDLE;
      pixcnt_q   <= '0;
      recv_q     <= 1'b0;
      comp_q     <= 1'b0;
      read_q     <= 1'b0;
      err_q      <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      wre_q      <= 1'b0;
      ce_q       <= 1'b0;
      gnt_q      <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pixcnt_q   <= pixcnt_d;
      recv_q     <= recv_d;
      comp_q     <= comp_d;
      read_q     <= read_d;
      err_q      <= err_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      wre_q      <= wr;
      ce_q       <= wr | rd;
      gnt_q      <= rd;
      rvalid_q   <= gnt_q;
    end

  assign o_rd_gnt          = gnt_q;
  assign o_rd_valid        = rvalid_q;
  assign o_rd_data         = rvalid_q ? i_ram_dout : '0;
  assign o_ram_addr        = ram_addr_q;
  assign o_ram_din         = ram_din_q;
  assign o_ram_wre         = wre_q;
  assign o_ram_ce          = ce_q;
  assign o_image_receiving = recv_q;
  assign o_image_complete  = comp_q;
  assign o_image_reading   = read_q;
  assign o_frame_err       = err_q;
  assign o_pixcnt          = pixcnt_q;
endmodule

// File: tb/tb_img_ram_ctrl.sv
// tb_img_ram_ctrl: directed frames against a frame-level model of the controller and an SRAM model
module tb_img_ram_ctrl;
  localparam int NPIX = 20;
  localparam int AW   = 15;
  localparam int DW   = 12;
`ifdef IMG_RAM_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 1_000_000;
`endif

  logic          clk = 1'b0, rst_n = 1'b1;
  logic [7:0]    byt = '0;
  logic          bv = 1'b0, rreq = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic          gnt, rvalid, wre, ce, recv, comp, reading, err;
  logic [DW-1:0] rdata, din, dout = '0;
  logic [AW-1:0] addr, pixcnt;
  int            total = 0, bad = 0, n;

  always #5 clk = ~clk;

  img_ram_ctrl #(.IMG_W(5), .IMG_H(4), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_byte(byt), .i_byte_valid(bv),
    .i_rd_req(rreq), .i_rd_addr(raddr), .o_rd_gnt(gnt), .o_rd_valid(rvalid), .o_rd_data(rdata),
    .o_ram_addr(addr), .o_ram_din(din), .o_ram_wre(wre), .o_ram_ce(ce), .i_ram_dout(dout),
    .o_image_receiving(recv), .o_image_complete(comp), .o_image_reading(reading),
    .o_frame_err(err), .o_pixcnt(pixcnt)
  );

  logic [DW-1:0] mem [NPIX];
  always @(posedge clk)
    if (ce && addr < AW'(NPIX)) begin
      if (wre) mem[addr] <= din;
      else dout <= mem[addr];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level model: mode 0 waits for a header, 1 takes pixel bytes, 2 expects the trailer
  int            m_mode = 0, m_idle = 0;
  logic          m_odd = 1'b0;
  logic [7:0]    m_hi = '0;
  logic [DW-1:0] img [NPIX];
  logic [AW-1:0] e_pix = '0, e_addr = '0;
  logic [DW-1:0] e_din = '0, e_rpend = '0, e_vdata = '0;
  logic          e_recv = 0, e_comp = 0, e_read = 0, e_err = 0, e_wre = 0, e_ce = 0, e_gnt = 0, e_val = 0;

  always @(posedge clk or negedge rst_n) begin
    logic w, r;
    if (!rst_n) begin
      m_mode = 0; m_idle = 0; m_odd = 0; m_hi = '0; e_pix = '0; e_addr = '0; e_din = '0;
      e_recv = 0; e_comp = 0; e_read = 0; e_err = 0; e_wre = 0; e_ce = 0; e_gnt = 0; e_val = 0;
    end else begin
      e_val   = e_gnt;
      e_vdata = e_rpend;
      w = bv && m_mode == 1 && m_odd;
      r = rreq && !w;
      if (r && e_comp) e_read = 1;
      if (w) begin
        e_addr = e_pix;
        e_din = {m_hi, byt[7:4]};
        img[e_pix] = e_din;
      end else if (r) begin
        e_addr = raddr;
        e_rpend = img[raddr];
      end
      e_wre = w; e_ce = w | r; e_gnt = r;
      if (bv) begin
        m_idle = 0;
        if (m_mode == 0) begin
          if (byt == 8'h5A) begin
            m_mode = 1; m_odd = 0; e_pix = '0; e_recv = 1; e_comp = 0; e_read = 0; e_err = 0;
          end
        end else if (m_mode == 1) begin
          if (!m_odd) begin m_hi = byt; m_odd = 1; end
          else begin
            m_odd = 0; e_pix = e_pix + 1'b1;
            if (e_pix == AW'(NPIX)) m_mode = 2;
          end
        end else begin
          m_mode = 0; e_recv = 0;
          if (byt == 8'h5A) e_comp = 1; else e_err = 1;
        end
      end else if (m_mode != 0) begin
        m_idle++;
`ifdef IMG_RAM_TIMEOUT_EN
        if (m_idle == TMO) begin m_mode = 0; m_idle = 0; e_err = 1; e_recv = 0; end
`endif
      end
    end
  end

  always @(negedge clk) begin
    chk("pixcnt", pixcnt, e_pix);
    chk("receiving", recv, e_recv);
    chk("complete", comp, e_comp);
    chk("reading", reading, e_read);
    chk("frame_err", err, e_err);
    chk("ram_wre", wre, e_wre);
    chk("ram_ce", ce, e_ce);
    chk("rd_gnt", gnt, e_gnt);
    chk("rd_valid", rvalid, e_val);
    if (e_ce) chk("ram_addr", addr, e_addr);
    if (e_wre) chk("ram_din", din, e_din);
    if (e_val) chk("rd_data", rdata, e_vdata);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    byt = b; bv = 1'b1; tick(); bv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NPIX; i++) begin mem[i] = '0; img[i] = '0; end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixcnt", pixcnt, 0);
    chk("rst_ce", ce, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_flags", {recv, comp, reading, err}, 0);
    rst_n = 1'b1;
    tick();
    // frame 1 with a read requester hammering address 0
    rreq = 1'b1; raddr = '0;
    send(8'h5A);
    send(8'hAB); send(8'hCD);
    chk("nibble_drop_din", din, 12'hABC);
    chk("nibble_drop_wre", wre, 1);
    send(8'h5A); send(8'h30);
    chk("hdr_as_data_din", din, 12'h5A3);
    chk("hdr_as_data_addr", addr, 1);
    chk("hdr_as_data_recv", recv, 1);
    for (int p = 2; p < NPIX; p++) begin send(8'($urandom)); send(8'($urandom)); end
    chk("pre_trailer_pixcnt", pixcnt, 20);
    send(8'h5A);
    chk("frame1_complete", comp, 1);
    chk("frame1_recv", recv, 0);
    chk("frame1_pixcnt", pixcnt, 20);
    tick();
    chk("frame1_reading", reading, 1);
    rreq = 1'b0;
    tick();
    // back-to-back readback of the whole image
    rreq = 1'b1;
    for (int a = 0; a < NPIX; a++) begin raddr = AW'(a); tick(); end
    rreq = 1'b0;
    repeat (3) tick();
    raddr = '0; rreq = 1'b1; tick();
    chk("single_rd_gnt", gnt, 1);
    rreq = 1'b0; tick();
    chk("single_rd_valid", rvalid, 1);
    chk("single_rd_data", rdata, 12'hABC);
    // frame 2: read/write collision then a bad trailer
    send(8'h5A);
    chk("frame2_hdr_flags", {recv, comp, reading, err}, 4'b1000);
    send(8'h12);
    byt = 8'h34; bv = 1'b1; rreq = 1'b1; raddr = AW'(1); tick(); bv = 1'b0;
    chk("collide_wre", wre, 1);
    chk("collide_no_gnt", gnt, 0);
    chk("collide_din", din, 12'h123);
    tick();
    chk("collide_late_gnt", gnt, 1);
    chk("collide_rd_addr", addr, 1);
    rreq = 1'b0; tick();
    chk("collide_rd_data", rdata, 12'h5A3);
    for (int p = 1; p < NPIX; p++) begin send(8'($urandom)); send(8'($urandom)); end
    send(8'h00);
    chk("bad_trailer_err", err, 1);
    chk("bad_trailer_flags", {recv, comp}, 0);
    send(8'h11);
    chk("idle_ignores_pixcnt", pixcnt, 20);
    send(8'h5A);
    chk("hdr_clears_err", err, 0);
    chk("hdr_clears_pixcnt", pixcnt, 0);
    send(8'h77); send(8'h88);
    chk("frame3_pixcnt", pixcnt, 1);
    // reset in the middle of a frame
    rst_n = 1'b0; #2;
    chk("midrst_port", {ce, wre, gnt, rvalid}, 0);
    chk("midrst_addr_din", {addr, din}, 0);
    chk("midrst_flags", {recv, comp, reading, err}, 0);
    chk("midrst_pixcnt_rdata", {pixcnt, rdata}, 0);
    tick(); rst_n = 1'b1; tick();
    send(8'h99);
    chk("post_rst_ignored", {pixcnt, recv}, 0);
    // spaced-out full frame
    send(8'h5A);
    for (int p = 0; p < 2 * NPIX; p++) begin send(8'($urandom)); tick(); end
    send(8'h5A);
    chk("spaced_complete", comp, 1);
`ifdef IMG_RAM_TIMEOUT_EN
    send(8'h5A);
    n = 0;
    while (!err && n < 150) begin tick(); n++; end
    chk("timeout_cycles", n, 100);
    chk("timeout_recv", recv, 0);
`endif
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
